regfile_mp_sb: RTL and testbench

// Parametrised multi-port integer register file with same-cycle write-to-read bypass and a per-register busy scoreboard.

---
 rtl/regfile_mp_sb_if.sv | 29 ++
 rtl/regfile_mp_sb.sv | 100 ++++++++++
 tb/tb_regfile_mp_sb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: write ports, read ports, and scoreboard set/observe.
// The master drives writes, read indices and issue marks; the slave returns read data and busy state.
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
);
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_id;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD*AW-1:0]   rd_id;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_id;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output wr_en, wr_id, wr_data, rd_id, sb_set_en, sb_set_id,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_id, wr_data, rd_id, sb_set_en, sb_set_id,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write-to-read bypass and per-register busy scoreboard.
// Optional REGFILE_DEBUG_EN adds a debug_regs port exposing the raw array (no bypass).
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_mp_sb_if.slave        rf
`ifdef REGFILE_DEBUG_EN
    ,
    output logic [NREGS*XLEN-1:0] debug_regs
`endif
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    // An id is "live" when it names a real, writable register (not hardwired zero, not out of range).
    function automatic logic id_live(input logic [AW-1:0] id);
        return (32'(id) < NREGS) && !((ZERO_REG != 0) && (id == '0));
    endfunction

    // Ports are visited in ascending order, so the last (highest-index) enabled port wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (rf.wr_en[p] && id_live(rf.wr_id[p*AW +: AW])) begin
                    regs_reg[rf.wr_id[p*AW +: AW]] <= rf.wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Clears first, then the set, so a new producer supersedes a retiring one.
    always_comb begin
        busy_next = busy_reg;
        for (int p = 0; p < NWR; p++) begin
            if (rf.wr_en[p] && id_live(rf.wr_id[p*AW +: AW])) begin
                busy_next[rf.wr_id[p*AW +: AW]] = 1'b0;
            end
        end
        if (rf.sb_set_en && id_live(rf.sb_set_id)) begin
            busy_next[rf.sb_set_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rf.busy_vec = busy_reg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   rd_id_cur;
            logic [XLEN-1:0] rd_data_next;
            logic            rd_busy_next;

            assign rd_id_cur = rf.rd_id[gi*AW +: AW];

            always_comb begin
                rd_data_next = '0;
                rd_busy_next = 1'b0;
                if (id_live(rd_id_cur)) begin
                    rd_data_next = regs_reg[rd_id_cur];
                    rd_busy_next = busy_reg[rd_id_cur];
                    for (int p = 0; p < NWR; p++) begin
                        if (rf.wr_en[p] && (rf.wr_id[p*AW +: AW] == rd_id_cur)) begin
                            rd_data_next = rf.wr_data[p*XLEN +: XLEN];
                            rd_busy_next = 1'b0;
                        end
                    end
                end
            end

            assign rf.rd_data[gi*XLEN +: XLEN] = rd_data_next;
            assign rf.rd_busy[gi]              = rd_busy_next;
        end

`ifdef REGFILE_DEBUG_EN
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_dbg
            assign debug_regs[gi*XLEN +: XLEN] = regs_reg[gi];
        end
`endif
    endgenerate
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_regfile_mp_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk;
    logic reset_n;

    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

`ifdef REGFILE_DEBUG_EN
    logic [NREGS*XLEN-1:0] debug_regs;
`endif

    regfile_mp_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rf(bus)
`ifdef REGFILE_DEBUG_EN
        ,
        .debug_regs(debug_regs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  busy;
        logic [31:0] bvec;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: the DUT output is combinational, so every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (bus.rd_data[0 +: 32] !== e.rd0 || bus.rd_data[32 +: 32] !== e.rd1 ||
                bus.rd_busy !== e.busy || bus.busy_vec !== e.bvec) begin
                n_bad++;
                $display("FAIL %s: got rd0=%h rd1=%h rd_busy=%b busy_vec=%h, want rd0=%h rd1=%h rd_busy=%b busy_vec=%h",
                         e.name, bus.rd_data[0 +: 32], bus.rd_data[32 +: 32], bus.rd_busy, bus.busy_vec,
                         e.rd0, e.rd1, e.busy, e.bvec);
            end else begin
                $display("ok   %s: rd0=%h rd1=%h rd_busy=%b busy_vec=%h",
                         e.name, e.rd0, e.rd1, e.busy, e.bvec);
            end
        end
    end

    // One cycle: drive inputs just after the edge and queue what the outputs must show during it.
    task automatic step(input logic rst_n, input logic [1:0] en,
                        input logic [4:0] i0, input logic [31:0] d0,
                        input logic [4:0] i1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic se, input logic [4:0] sid,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [1:0] eb, input logic [31:0] ev,
                        input string nm);
        exp_t e;
        #1;
        reset_n       = rst_n;
        bus.wr_en     = en;
        bus.wr_id     = {i1, i0};
        bus.wr_data   = {d1, d0};
        bus.rd_id     = {r1, r0};
        bus.sb_set_en = se;
        bus.sb_set_id = sid;
        e.name = nm; e.rd0 = e0; e.rd1 = e1; e.busy = eb; e.bvec = ev;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.wr_en     = 2'b01;
        bus.wr_id     = {5'd0, 5'd5};
        bus.wr_data   = {32'h0, 32'h0000_0099};
        bus.rd_id     = '0;
        bus.sb_set_en = 1'b1;
        bus.sb_set_id = 5'd6;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NREGS; i++) begin
            step(1, 2'b00, 0, 0, 0, 0, 5'(i), 5'(NREGS-1-i), 0, 0,
                 32'h0, 32'h0, 2'b00, 32'h0, $sformatf("reset_read_%0d", i));
        end

        step(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0, 0,
             32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0, "bypass_id5");
        step(1, 2'b00, 0, 0, 0, 0, 5, 6, 0, 0,
             32'hDEADBEEF, 32'h0, 2'b00, 32'h0, "stored_id5");

        step(1, 2'b11, 7, 32'h11, 7, 32'h22, 7, 5, 0, 0,
             32'h22, 32'hDEADBEEF, 2'b00, 32'h0, "dual_write_bypass");
        step(1, 2'b00, 0, 0, 0, 0, 7, 7, 0, 0,
             32'h22, 32'h22, 2'b00, 32'h0, "dual_write_stored");
        step(1, 2'b01, 8, 32'h33, 7, 32'h77, 7, 8, 0, 0,
             32'h22, 32'h33, 2'b00, 32'h0, "disabled_port_no_fwd");
        step(1, 2'b00, 0, 0, 0, 0, 8, 7, 0, 0,
             32'h33, 32'h22, 2'b00, 32'h0, "disabled_port_no_write");

        step(1, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0,
             32'h0, 32'h0, 2'b00, 32'h0, "zero_reg_write");
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
             32'h0, 32'h0, 2'b00, 32'h0, "zero_reg_after");

        step(1, 2'b00, 0, 0, 0, 0, 3, 3, 1, 3,
             32'h0, 32'h0, 2'b00, 32'h0, "sb_set3_same_cycle");
        step(1, 2'b00, 0, 0, 0, 0, 3, 5, 0, 0,
             32'h0, 32'hDEADBEEF, 2'b01, 32'h0000_0008, "busy3_visible");
        step(1, 2'b01, 3, 32'h42, 0, 0, 3, 3, 0, 0,
             32'h42, 32'h42, 2'b00, 32'h0000_0008, "write3_bypass_clears_busy");
        step(1, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0,
             32'h42, 32'h0, 2'b00, 32'h0, "busy3_cleared");

        step(1, 2'b00, 0, 0, 0, 0, 9, 9, 1, 9,
             32'h0, 32'h0, 2'b00, 32'h0, "sb_set9");
        step(1, 2'b10, 0, 0, 9, 32'h99, 9, 1, 1, 9,
             32'h99, 32'h0, 2'b00, 32'h0000_0200, "set_and_clear9");
        step(1, 2'b00, 0, 0, 0, 0, 9, 9, 0, 0,
             32'h99, 32'h99, 2'b11, 32'h0000_0200, "set_wins9");
        step(0, 2'b01, 10, 32'h55, 0, 0, 10, 9, 1, 4,
             32'h55, 32'h99, 2'b10, 32'h0000_0200, "reset_cycle");
        step(1, 2'b00, 0, 0, 0, 0, 10, 9, 0, 0,
             32'h0, 32'h0, 2'b00, 32'h0, "after_reset");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 time units, want completion");
        $fatal(1, "timeout");
    end
endmodule
